// File: rtl/display_hdmi_pkg.sv
// Shared types and helpers for the HDMI display read-path scheduler.
package display_hdmi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    PREFILL = 3'd2,
    WAIT_VS = 3'd3,
    RUN     = 3'd4,
    FLUSH   = 3'd5,
    DRAIN   = 3'd6
  } sched_state_t;

  localparam int CNT_W = 21;

  function automatic int frame_beats(input int w, input int h, input int ppc);
    return (w * h) / ppc;
  endfunction

endpackage

// File: rtl/display_hdmi_buf_select.sv
// Tracks the most recently written frame buffer and produces the DMA base address.
module display_hdmi_buf_select
  import display_hdmi_pkg::*;
#(
  parameter int NUM_BUF = 3
) (
  input  logic                   iHdmiClk,
  input  logic                   iRst_n,
  input  logic [32*NUM_BUF-1:0]  ivBufBase,
  input  logic                   iWrDoneValid,
  input  logic [1:0]             ivWrDoneIdx,
  input  logic                   iLoad,
  input  logic                   iHold,
  output logic [31:0]            ov32Addr
);

  logic [1:0]  rLatestIdx;
  logic [1:0]  rCurIdx;
  logic [31:0] rAddr;
  logic [31:0] latestBase;
  logic [31:0] curBase;

  always_comb begin
    latestBase = '0;
    curBase    = '0;
    for (int k = 0; k < NUM_BUF; k++) begin
      if (rLatestIdx == k[1:0]) latestBase = ivBufBase[32*k +: 32];
      if (rCurIdx == k[1:0])    curBase    = ivBufBase[32*k +: 32];
    end
  end

  // A load samples rLatestIdx before any same-cycle write-done update lands.
  always_ff @(posedge iHdmiClk) begin
    if (!iRst_n) begin
      rLatestIdx <= '0;
      rCurIdx    <= '0;
      rAddr      <= '0;
    end else begin
      if (iWrDoneValid && (int'(ivWrDoneIdx) < NUM_BUF)) rLatestIdx <= ivWrDoneIdx;
      if (iLoad) begin
        rCurIdx <= rLatestIdx;
        rAddr   <= latestBase;
      end else if (iHold) begin
        rAddr   <= curBase;
      end else begin
        rAddr   <= '0;
      end
    end
  end

  assign ov32Addr = rAddr;

endmodule

// File: rtl/display_hdmi_frame_sched.sv
// Per-frame scheduler: DMA request sequencing, prefill, vsync alignment,
// FIFO read gating and flush/re-sync recovery on underflow or misalignment.
//
// state   | meaning
// IDLE    | display disabled, all outputs quiet
// REQ     | frame read request held until ack
// PREFILL | waiting for FIFO level to pass the prefill threshold
// WAIT_VS | prefilled, waiting for the start of a frame
// RUN     | streaming FIFO beats to the display
// FLUSH   | abort DMA, clear FIFO, pad white
// DRAIN   | waiting for the DMA to go idle before restarting
module display_hdmi_frame_sched
  import display_hdmi_pkg::*;
#(
  parameter int FRAME_WIDTH    = 1920,
  parameter int FRAME_HEIGHT   = 1080,
  parameter int PPC            = 2,
  parameter int BYTES_PER_BEAT = 8,
  parameter int NUM_BUF        = 3,
  parameter int FIFO_DEPTH     = 4096,
  parameter int PREFILL_LEVEL  = 2048,
  parameter int FLUSH_CYCLES   = 16
) (
  input  logic                  iHdmiClk,
  input  logic                  iRst_n,
  input  logic                  iEnable,
  input  logic [32*NUM_BUF-1:0] ivBufBase,
  input  logic                  iWrDoneValid,
  input  logic [1:0]            ivWrDoneIdx,
  output logic                  oDmaReq,
  output logic [31:0]           ov32DmaAddr,
  output logic [31:0]           ov32DmaLen,
  input  logic                  iDmaAck,
  input  logic                  iDmaDone,
  output logic                  oDmaAbort,
  input  logic                  iDmaIdle,
  input  logic [11:0]           ivFifoCount,
  input  logic                  iFifoUnderflow,
  output logic                  oFifoFlush,
  input  logic                  iVgaVs,
  input  logic                  iVgaVd,
  output logic                  oFifoRdEn,
  output logic                  oDataSel,
  output logic [2:0]            ov3State,
  output logic [15:0]           ov16ResyncCnt
);

  localparam int               FrameBeats  = frame_beats(FRAME_WIDTH, FRAME_HEIGHT, PPC);
  localparam logic [CNT_W-1:0] FrameBeatsC = CNT_W'(FrameBeats);
  localparam logic [31:0]      DmaLen      = 32'(FrameBeats * BYTES_PER_BEAT);
  localparam int               PrefillThr  = (PREFILL_LEVEL < FIFO_DEPTH) ? PREFILL_LEVEL : FIFO_DEPTH - 1;
  localparam logic [11:0]      PrefillThrC = 12'(PrefillThr);
  localparam int               FlushW      = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FlushW-1:0] FlushLoad  = FlushW'(FLUSH_CYCLES - 1);

  sched_state_t      rState;
  sched_state_t      stateNext;
  logic              rVsPrev;
  logic              rVsFall;
  logic              rVsRise;
  logic              rFirst;
  logic              rSkipCheck;
  logic              rNextReq;
  logic [CNT_W-1:0]  rBeatCnt;
  logic [FlushW-1:0] rFlushTmr;
  logic              rAbort;
  logic              rFlush;
  logic              rDataSel;
  logic [15:0]       rResyncCnt;

  logic live;
  logic fifoRdEn;
  logic underflow;
  logic misalign;
  logic flushEntry;
  logic reqLoad;
  logic reqHold;
  logic firstNext;
  logic nextLive;

  // Reads stay live through a REQ visit that interrupts streaming.
  assign live      = (rState == RUN) || ((rState == REQ) && !rFirst);
  assign fifoRdEn  = live & iVgaVd;
  assign underflow = live & (iFifoUnderflow | (fifoRdEn & (ivFifoCount == '0)));
  assign misalign  = live & rVsFall & ~rSkipCheck & (rBeatCnt != FrameBeatsC);

  always_comb begin
    stateNext = rState;
    case (rState)
      IDLE:    if (iEnable) stateNext = REQ;
      REQ: begin
        if (!iEnable || underflow || misalign) stateNext = FLUSH;
        else if (iDmaAck)                      stateNext = rFirst ? PREFILL : RUN;
      end
      PREFILL: begin
        if (!iEnable)                        stateNext = FLUSH;
        else if (ivFifoCount > PrefillThrC)  stateNext = WAIT_VS;
      end
      WAIT_VS: begin
        if (!iEnable)     stateNext = FLUSH;
        else if (rVsRise) stateNext = RUN;
      end
      RUN: begin
        if (!iEnable || underflow || misalign) stateNext = FLUSH;
        else if (rNextReq)                     stateNext = REQ;
      end
      FLUSH:   if (rFlushTmr == '0) stateNext = DRAIN;
      DRAIN:   if (iDmaIdle) stateNext = iEnable ? REQ : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    flushEntry = (stateNext == FLUSH) && (rState != FLUSH);
    reqLoad    = (stateNext == REQ) && (rState != REQ);
    reqHold    = (stateNext == REQ) && (rState == REQ);
    firstNext  = rFirst;
    if (((rState == IDLE) || (rState == DRAIN)) && (stateNext == REQ)) firstNext = 1'b1;
    else if (stateNext == RUN)                                         firstNext = 1'b0;
    nextLive = (stateNext == RUN) || ((stateNext == REQ) && !firstNext);
  end

  always_ff @(posedge iHdmiClk) begin
    if (!iRst_n) begin
      rState     <= IDLE;
      rVsPrev    <= 1'b1;
      rVsFall    <= 1'b0;
      rVsRise    <= 1'b0;
      rFirst     <= 1'b1;
      rSkipCheck <= 1'b0;
      rNextReq   <= 1'b0;
      rBeatCnt   <= '0;
      rFlushTmr  <= '0;
      rAbort     <= 1'b0;
      rFlush     <= 1'b0;
      rDataSel   <= 1'b0;
      rResyncCnt <= '0;
    end else begin
      rState   <= stateNext;
      rVsPrev  <= iVgaVs;
      rVsFall  <= rVsPrev & ~iVgaVs;
      rVsRise  <= ~rVsPrev & iVgaVs;
      rFirst   <= firstNext;
      rAbort   <= flushEntry;
      rFlush   <= (stateNext == FLUSH);
      rDataSel <= nextLive;

      if (flushEntry)                                rFlushTmr <= FlushLoad;
      else if ((rState == FLUSH) && (rFlushTmr != '0)) rFlushTmr <= rFlushTmr - 1'b1;

      if (flushEntry && (rResyncCnt != 16'hFFFF)) rResyncCnt <= rResyncCnt + 16'd1;

      if (reqLoad || (rState == FLUSH))                           rNextReq <= 1'b0;
      else if (iDmaDone && ((rState == RUN) || (rState == REQ)))  rNextReq <= 1'b1;

      // The first frame after alignment may be partial, so its count is not judged.
      if ((rState == WAIT_VS) && (stateNext == RUN)) begin
        rBeatCnt   <= '0;
        rSkipCheck <= 1'b1;
      end else if (live && rVsFall) begin
        rBeatCnt   <= fifoRdEn ? CNT_W'(1) : '0;
        rSkipCheck <= 1'b0;
      end else if (fifoRdEn && (rBeatCnt != '1)) begin
        rBeatCnt   <= rBeatCnt + 1'b1;
      end
    end
  end

  display_hdmi_buf_select #(
    .NUM_BUF (NUM_BUF)
  ) uBufSelect (
    .iHdmiClk     (iHdmiClk),
    .iRst_n       (iRst_n),
    .ivBufBase    (ivBufBase),
    .iWrDoneValid (iWrDoneValid),
    .ivWrDoneIdx  (ivWrDoneIdx),
    .iLoad        (reqLoad),
    .iHold        (reqHold),
    .ov32Addr     (ov32DmaAddr)
  );

  assign oDmaReq       = (rState == REQ);
  assign ov32DmaLen    = DmaLen;
  assign oDmaAbort     = rAbort;
  assign oFifoFlush    = rFlush;
  assign oFifoRdEn     = fifoRdEn;
  assign oDataSel      = rDataSel;
  assign ov3State      = rState;
  assign ov16ResyncCnt = rResyncCnt;

endmodule

// File: tb/tb_display_hdmi_frame_sched.sv
// Directed bench for the HDMI frame scheduler using a 16-beat test frame.
module tb_display_hdmi_frame_sched;

  localparam int FW = 16;
  localparam int FH = 2;
  localparam int PP = 2;
  localparam int FB = FW * FH / PP;

  logic        iHdmiClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iEnable = 1'b0;
  logic [95:0] ivBufBase = {32'h1200_0000, 32'h1100_0000, 32'h1000_0000};
  logic        iWrDoneValid = 1'b0;
  logic [1:0]  ivWrDoneIdx = 2'd0;
  logic        iDmaAck = 1'b0;
  logic        iDmaDone = 1'b0;
  logic        iDmaIdle = 1'b1;
  logic [11:0] ivFifoCount = 12'd0;
  logic        iFifoUnderflow = 1'b0;
  logic        iVgaVs = 1'b1;
  logic        iVgaVd = 1'b0;
  logic        oDmaReq, oDmaAbort, oFifoFlush, oFifoRdEn, oDataSel;
  logic [31:0] ov32DmaAddr, ov32DmaLen;
  logic [2:0]  ov3State;
  logic [15:0] ov16ResyncCnt;

  int   nChecks = 0;
  int   nFail = 0;
  int   nReq = 0;
  logic reqQ = 1'b0;

  display_hdmi_frame_sched #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .PPC(PP), .BYTES_PER_BEAT(8),
    .NUM_BUF(3), .FIFO_DEPTH(4096), .PREFILL_LEVEL(2048), .FLUSH_CYCLES(16)
  ) dut (
    .iHdmiClk(iHdmiClk), .iRst_n(iRst_n), .iEnable(iEnable), .ivBufBase(ivBufBase),
    .iWrDoneValid(iWrDoneValid), .ivWrDoneIdx(ivWrDoneIdx), .oDmaReq(oDmaReq),
    .ov32DmaAddr(ov32DmaAddr), .ov32DmaLen(ov32DmaLen), .iDmaAck(iDmaAck),
    .iDmaDone(iDmaDone), .oDmaAbort(oDmaAbort), .iDmaIdle(iDmaIdle),
    .ivFifoCount(ivFifoCount), .iFifoUnderflow(iFifoUnderflow), .oFifoFlush(oFifoFlush),
    .iVgaVs(iVgaVs), .iVgaVd(iVgaVd), .oFifoRdEn(oFifoRdEn), .oDataSel(oDataSel),
    .ov3State(ov3State), .ov16ResyncCnt(ov16ResyncCnt)
  );

  always #5 iHdmiClk = ~iHdmiClk;

  always @(negedge iHdmiClk) begin
    if (oDmaReq && !reqQ) nReq <= nReq + 1;
    reqQ <= oDmaReq;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    nChecks++;
    assert (obs === want) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge iHdmiClk);
    #1;
  endtask

  // vsync low for one cycle; fall acted on at the 2nd edge, rise at the 3rd.
  task automatic vsync();
    iVgaVd = 1'b0;
    iVgaVs = 1'b0;
    tick(1);
    iVgaVs = 1'b1;
    tick(2);
  endtask

  // One full frame of FB beats with a DMA done/request/ack inside the active region.
  task automatic runFrame(input logic [31:0] expAddr, input logic wrAtReq, input logic [1:0] wrIdx);
    iVgaVd = 1'b1;
    iDmaDone = 1'b1;
    tick(1);
    iDmaDone = 1'b0;
    if (wrAtReq) begin
      iWrDoneValid = 1'b1;
      ivWrDoneIdx = wrIdx;
    end
    tick(1);
    iWrDoneValid = 1'b0;
    chk("reqState", 32'(ov3State), 32'd1);
    chk("reqAddr", ov32DmaAddr, expAddr);
    chk("reqRdLive", 32'(oFifoRdEn), 32'd1);
    chk("reqSelLive", 32'(oDataSel), 32'd1);
    iDmaAck = 1'b1;
    tick(1);
    iDmaAck = 1'b0;
    chk("ackToRun", 32'(ov3State), 32'd4);
    tick(FB - 3);
    vsync();
    chk("frameAligned", 32'(ov3State), 32'd4);
  endtask

  // From the first FLUSH cycle back to aligned streaming, including the unchecked first frame.
  task automatic recover(input logic [31:0] expAddr);
    tick(15);
    chk("flushWidth", 32'(oFifoFlush), 32'd1);
    tick(1);
    chk("drainState", 32'(ov3State), 32'd6);
    chk("flushEnd", 32'(oFifoFlush), 32'd0);
    tick(1);
    chk("reReqState", 32'(ov3State), 32'd1);
    iDmaAck = 1'b1;
    tick(1);
    iDmaAck = 1'b0;
    chk("rePrefill", 32'(ov3State), 32'd2);
    ivFifoCount = 12'd3000;
    tick(1);
    chk("reWaitVs", 32'(ov3State), 32'd3);
    vsync();
    chk("reRun", 32'(ov3State), 32'd4);
    ivFifoCount = 12'd100;
    runFrame(expAddr, 1'b0, 2'd0);
  endtask

  initial begin
    tick(3);
    chk("rstState", 32'(ov3State), 32'd0);
    chk("rstReq", 32'(oDmaReq), 32'd0);
    chk("rstAddr", ov32DmaAddr, 32'd0);
    chk("dmaLen", ov32DmaLen, 32'd128);
    chk("rstAbort", 32'(oDmaAbort), 32'd0);
    chk("rstFlush", 32'(oFifoFlush), 32'd0);
    chk("rstRdEn", 32'(oFifoRdEn), 32'd0);
    chk("rstSel", 32'(oDataSel), 32'd0);
    chk("rstResync", 32'(ov16ResyncCnt), 32'd0);

    // Prefill and alignment
    iRst_n = 1'b1;
    iEnable = 1'b1;
    tick(1);
    chk("firstReq", 32'(oDmaReq), 32'd1);
    chk("firstAddr", ov32DmaAddr, 32'h1000_0000);
    tick(3);
    chk("reqHeld", 32'(oDmaReq), 32'd1);
    chk("addrStable", ov32DmaAddr, 32'h1000_0000);
    iDmaAck = 1'b1;
    tick(1);
    iDmaAck = 1'b0;
    chk("prefillState", 32'(ov3State), 32'd2);
    chk("reqDropped", 32'(oDmaReq), 32'd0);
    ivFifoCount = 12'd1000;
    tick(1);
    chk("prefillLow", 32'(ov3State), 32'd2);
    ivFifoCount = 12'd2048;
    tick(1);
    chk("prefillEqual", 32'(ov3State), 32'd2);
    ivFifoCount = 12'd2049;
    tick(1);
    chk("waitVsState", 32'(ov3State), 32'd3);
    iVgaVd = 1'b1;
    #1;
    chk("waitNoRd", 32'(oFifoRdEn), 32'd0);
    chk("waitPadWhite", 32'(oDataSel), 32'd0);
    tick(2);
    chk("waitHolds", 32'(ov3State), 32'd3);
    vsync();
    chk("alignedRun", 32'(ov3State), 32'd4);
    chk("alignedSel", 32'(oDataSel), 32'd1);
    ivFifoCount = 12'd100;

    // Steady state and buffer selection
    runFrame(32'h1000_0000, 1'b0, 2'd0);
    iWrDoneValid = 1'b1;
    ivWrDoneIdx = 2'd1;
    tick(1);
    iWrDoneValid = 1'b0;
    runFrame(32'h1100_0000, 1'b0, 2'd0);
    runFrame(32'h1100_0000, 1'b1, 2'd2);
    runFrame(32'h1200_0000, 1'b0, 2'd0);
    chk("reqCount", 32'(nReq), 32'd5);
    chk("steadyResync", 32'(ov16ResyncCnt), 32'd0);

    // Underflow by reading an empty FIFO
    iVgaVd = 1'b1;
    ivFifoCount = 12'd0;
    #1;
    chk("uflRdComb", 32'(oFifoRdEn), 32'd1);
    tick(1);
    chk("uflFlushState", 32'(ov3State), 32'd5);
    chk("uflAbort", 32'(oDmaAbort), 32'd1);
    chk("uflFlush", 32'(oFifoFlush), 32'd1);
    chk("uflSel", 32'(oDataSel), 32'd0);
    chk("uflRdGated", 32'(oFifoRdEn), 32'd0);
    chk("uflResync", 32'(ov16ResyncCnt), 32'd1);
    iVgaVd = 1'b0;
    tick(1);
    chk("abortOneCycle", 32'(oDmaAbort), 32'd0);
    chk("flushStillHigh", 32'(oFifoFlush), 32'd1);
    tick(14);
    chk("flush16th", 32'(oFifoFlush), 32'd1);
    tick(1);
    chk("uflDrain", 32'(ov3State), 32'd6);
    tick(1);
    chk("uflReReq", 32'(ov3State), 32'd1);
    chk("uflReAddr", ov32DmaAddr, 32'h1200_0000);
    iDmaAck = 1'b1;
    tick(1);
    iDmaAck = 1'b0;
    chk("uflRePrefill", 32'(ov3State), 32'd2);
    ivFifoCount = 12'd3000;
    tick(1);
    chk("uflReWait", 32'(ov3State), 32'd3);
    iVgaVd = 1'b1;
    #1;
    chk("uflNoRdBeforeVs", 32'(oFifoRdEn), 32'd0);
    vsync();
    chk("uflResumed", 32'(oDataSel), 32'd1);
    ivFifoCount = 12'd100;

    // Misalignment: 10 beats short
    runFrame(32'h1200_0000, 1'b0, 2'd0);
    iVgaVd = 1'b1;
    tick(FB - 10);
    iVgaVd = 1'b0;
    iVgaVs = 1'b0;
    tick(1);
    chk("shortNoFlushYet", 32'(ov3State), 32'd4);
    iVgaVs = 1'b1;
    tick(1);
    chk("misFlush", 32'(ov3State), 32'd5);
    chk("misAbort", 32'(oDmaAbort), 32'd1);
    chk("misResync", 32'(ov16ResyncCnt), 32'd2);
    recover(32'h1200_0000);

    // Misalignment with a same-cycle underflow flag
    iVgaVd = 1'b1;
    tick(FB - 10);
    iVgaVd = 1'b0;
    iVgaVs = 1'b0;
    tick(1);
    iVgaVs = 1'b1;
    iFifoUnderflow = 1'b1;
    tick(1);
    iFifoUnderflow = 1'b0;
    chk("bothFlush", 32'(ov3State), 32'd5);
    chk("bothResync", 32'(ov16ResyncCnt), 32'd3);
    recover(32'h1200_0000);
    chk("bothOneResync", 32'(ov16ResyncCnt), 32'd3);

    // Enable drop while streaming
    iEnable = 1'b0;
    iDmaIdle = 1'b0;
    tick(1);
    chk("disFlush", 32'(ov3State), 32'd5);
    chk("disAbort", 32'(oDmaAbort), 32'd1);
    chk("disResync", 32'(ov16ResyncCnt), 32'd4);
    tick(16);
    chk("disDrain", 32'(ov3State), 32'd6);
    tick(3);
    chk("drainHold", 32'(ov3State), 32'd6);
    iDmaIdle = 1'b1;
    tick(1);
    chk("disIdle", 32'(ov3State), 32'd0);
    chk("idleReq", 32'(oDmaReq), 32'd0);
    chk("idleAbort", 32'(oDmaAbort), 32'd0);
    chk("idleFlush", 32'(oFifoFlush), 32'd0);
    chk("idleRdEn", 32'(oFifoRdEn), 32'd0);
    chk("idleSel", 32'(oDataSel), 32'd0);

    // Reset while streaming
    iEnable = 1'b1;
    tick(1);
    iDmaAck = 1'b1;
    tick(1);
    iDmaAck = 1'b0;
    ivFifoCount = 12'd3000;
    tick(1);
    vsync();
    chk("preRstRun", 32'(ov3State), 32'd4);
    iRst_n = 1'b0;
    tick(1);
    chk("midRstState", 32'(ov3State), 32'd0);
    chk("midRstSel", 32'(oDataSel), 32'd0);
    chk("midRstResync", 32'(ov16ResyncCnt), 32'd0);
    chk("midRstAddr", ov32DmaAddr, 32'd0);
    iRst_n = 1'b1;
    tick(1);
    chk("postRstReq", 32'(ov3State), 32'd1);
    chk("postRstAddr", ov32DmaAddr, 32'h1000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
